apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the APB_Protocol bridge.
- Accepts complete read/write commands from two clients and serialises them onto the bridge's transfer / READ_WRITE / address / data inputs.
- Returns read data and PSLVERR status to the granted client with a one-cycle done pulse.
- Optional watchdog aborts transactions that never complete.

Parameters:
- ADDR_W, 9: address width; MSB selects slave 1/slave 2 in the bridge.
- DATA_W, 8: data width.
- TIMEOUT, 15: maximum ACCESS cycles before abort; only used with ARB_TIMEOUT_EN; must be >= 1.

Ports:
- PCLK  in  1  clock, rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- req0, req1  in  1  request, held by the client until its done pulse.
- wr0, wr1  in  1  1 = write, 0 = read.
- addr0, addr1  in  ADDR_W  transaction address.
- wdata0, wdata1  in  DATA_W  write data.
- gnt  out  2  one-hot current grant; 00 = none.
- done0, done1  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read data; valid while a done pulse is high.
- err  out  1  error flag; valid while a done pulse is high.
- transfer  out  1  to bridge: transaction active.
- READ_WRITE  out  1  to bridge: 1 = read, 0 = write.
- apb_write_paddr  out  ADDR_W  to bridge.
- apb_write_data  out  DATA_W  to bridge.
- apb_read_paddr  out  ADDR_W  to bridge.
- apb_read_data_out  in  DATA_W  from bridge.
- PSLVERR  in  1  from bridge.
- m_pready  in  1  from bridge: access phase completes this cycle.

Behaviour:
- Reset values (PRESET=1): state IDLE; all outputs 0; round-robin pointer favours requester 0; timeout counter 0.
- States: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Single request: that requester wins.
  - Both requesting: the requester not served last wins.
  - On a win: latch wr/addr/wdata of the winner, set gnt, go to SETUP.
  - No request: stay in IDLE with transfer=0.
- SETUP (exactly 1 cycle):
  - transfer=1, READ_WRITE=~wr.
  - Both apb_write_paddr and apb_read_paddr = latched addr; apb_write_data = latched wdata.
  - Go to ACCESS.
- ACCESS:
  - transfer held at 1; all command outputs held stable.
  - m_pready=1: capture apb_read_data_out into rdata (reads only; writes give rdata=0) and PSLVERR into err, then go to DONE.
  - m_pready=0: stay in ACCESS.
- DONE (1 cycle):
  - transfer=0, gnt=00.
  - done0 or done1 pulses for the served requester; rdata and err valid this cycle only, 0 otherwise.
  - Update the round-robin pointer; go to IDLE.
- Latency: with m_pready in the first ACCESS cycle, a request sampled at edge N gives SETUP at N+1, ACCESS at N+2 and a done pulse at N+3. Throughput is at most one transaction per 4 cycles.
- transfer is low for at least 2 cycles (DONE + IDLE) between transactions.
- Commands are latched, so client inputs may change after the grant.
- req dropped mid-transaction: ignored; the transaction completes and done still pulses.
- A client holding req through its done pulse is eligible again in the following IDLE cycle under round-robin.
- PRESET mid-transaction: next cycle is IDLE, transfer=0, gnt=00, no done pulse; the pointer returns to favouring requester 0.
- done0 and done1 are never high together; gnt is always one-hot or zero.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments on each ACCESS cycle without m_pready.
  - When the counter reaches TIMEOUT: go to DONE with err=1 and rdata=0.
  - m_pready arriving in the same cycle as the timeout takes priority (normal completion).
- Undefined: no counter; ACCESS waits for m_pready indefinitely.

Test Plan:
- Write, m_pready in first ACCESS cycle: req0, wr0=1, addr0=0x005, wdata0=0x0A -> transfer high exactly 2 cycles; READ_WRITE=0; apb_write_paddr=0x005, apb_write_data=0x0A; done0 at N+3; err=0.
- Simultaneous reads after reset: req0 addr 0x003 and req1 addr 0x103; bridge returns 0x06 then 0x03 -> gnt=01 first with rdata=0x06, then gnt=10 with rdata=0x03; done0 precedes done1.
- Fairness: req0 and req1 held high for 6 transactions -> grants alternate 0,1,0,1,0,1; never two consecutive grants to the same requester.
- Error: read addr0=0x02D with PSLVERR=1 and m_pready=1 -> done0 with err=1; the next transaction completing without PSLVERR gives err=0.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=15): m_pready held at 0 -> done pulse after 15 ACCESS cycles with err=1, rdata=0x00. Without the macro, transfer stays at 1 indefinitely.
- Reset mid-ACCESS: PRESET for 1 cycle while gnt=10 -> next cycle transfer=0, gnt=00, no done; with req0 and req1 both pending afterwards, requester 0 is granted first.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter that serialises client commands onto the APB bridge.
// Define ARB_TIMEOUT_EN to add a watchdog that aborts ACCESS after TIMEOUT cycles.
module apb_req_arbiter #(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              req0,
   input  logic              req1,
   input  logic              wr0,
   input  logic              wr1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic [1:0]        gnt,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              transfer,
   output logic              READ_WRITE,
   output logic [ADDR_W-1:0] apb_write_paddr,
   output logic [DATA_W-1:0] apb_write_data,
   output logic [ADDR_W-1:0] apb_read_paddr,
   input  logic [DATA_W-1:0] apb_read_data_out,
   input  logic              PSLVERR,
   input  logic              m_pready
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   if (TIMEOUT < 1) begin : g_timeout_check
      $error("apb_req_arbiter: TIMEOUT must be >= 1");
   end

   logic [1:0]        state;
   logic              owner;        // requester being served: 0 or 1
   logic              last_served;  // requester served most recently
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic              win_any;
   logic              win_id;
   logic              active;
   logic              timed_out;

   // On contention the requester that was not served last wins.
   always_comb begin
      win_any = req0 | req1;
      win_id  = (req0 & req1) ? ~last_served : req1;
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] to_cnt;

   // Expires on the TIMEOUT-th ACCESS cycle without m_pready.
   assign timed_out = (state == ACCESS) && !m_pready && (to_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge PCLK) begin
      if (PRESET)
         to_cnt <= '0;
      else if (state == SETUP)
         to_cnt <= '0;
      else if (state == ACCESS && !m_pready)
         to_cnt <= to_cnt + CNT_W'(1);
   end
`else
   assign timed_out = 1'b0;
`endif

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state       <= IDLE;
         owner       <= 1'b0;
         last_served <= 1'b1;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (win_any) begin
                  owner   <= win_id;
                  wr_q    <= win_id ? wr1    : wr0;
                  addr_q  <= win_id ? addr1  : addr0;
                  wdata_q <= win_id ? wdata1 : wdata0;
                  state   <= SETUP;
               end
            end
            SETUP: state <= ACCESS;
            ACCESS: begin
               if (m_pready) begin
                  rdata_q <= wr_q ? '0 : apb_read_data_out;
                  err_q   <= PSLVERR;
                  state   <= DONE;
               end else if (timed_out) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               // Result registers only hold data during the DONE cycle.
               last_served <= owner;
               rdata_q     <= '0;
               err_q       <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign active          = (state == SETUP) || (state == ACCESS);
   assign transfer        = active;
   assign gnt             = active ? (owner ? 2'b10 : 2'b01) : 2'b00;
   assign done0           = (state == DONE) && !owner;
   assign done1           = (state == DONE) && owner;
   assign rdata           = rdata_q;
   assign err             = err_q;
   assign READ_WRITE      = active & ~wr_q;
   assign apb_write_paddr = active ? addr_q  : '0;
   assign apb_read_paddr  = active ? addr_q  : '0;
   assign apb_write_data  = active ? wdata_q : '0;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: vector table, directed corner cases and
// randomized traffic against a transaction-level round-robin model.
module tb_apb_req_arbiter;

   localparam int ADDR_W  = 9;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 15;

   logic              PCLK = 1'b0;
   logic              PRESET = 1'b1;
   logic              req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
   logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
   logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
   logic [1:0]        gnt;
   logic              done0, done1, err, transfer, READ_WRITE;
   logic [DATA_W-1:0] rdata, apb_write_data;
   logic [ADDR_W-1:0] apb_write_paddr, apb_read_paddr;
   logic [DATA_W-1:0] apb_read_data_out = '0;
   logic              PSLVERR = 1'b0, m_pready = 1'b0;

   always #5 PCLK = ~PCLK;

   apb_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt(gnt), .done0(done0), .done1(done1), .rdata(rdata), .err(err),
      .transfer(transfer), .READ_WRITE(READ_WRITE),
      .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
      .apb_read_paddr(apb_read_paddr), .apb_read_data_out(apb_read_data_out),
      .PSLVERR(PSLVERR), .m_pready(m_pready)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int inv_viol = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   always @(negedge PCLK) begin
      if ((done0 && done1) || gnt == 2'b11) inv_viol++;
   end

   initial begin
      #500000;
      $display("FAIL global time limit reached");
      $fatal(1, "bench time limit");
   end

   typedef struct {
      logic r0; logic w0; logic [8:0] a0; logic [7:0] d0;
      logic r1; logic w1; logic [8:0] a1; logic [7:0] d1;
      logic [7:0] brd; logic perr; int wait_c; logic scr;
      logic [1:0] e_gnt; logic e_rw; logic [8:0] e_addr; logic [7:0] e_wd;
      logic [7:0] e_rd; logic e_err; int e_lat;
   } vec_t;

   // One transaction from grant to done; returns on the DONE-cycle negedge.
   task automatic run_txn(input string tag, input logic [1:0] e_gnt, input logic e_rw,
                          input logic [ADDR_W-1:0] e_addr, input logic [DATA_W-1:0] e_wd,
                          input logic [DATA_W-1:0] brd, input logic perr, input int wait_c,
                          input logic scr, input logic [DATA_W-1:0] e_rd, input logic e_err,
                          input int e_lat);
      int n;
      n = 0;
      @(negedge PCLK);
      n++;
      while (gnt == 2'b00 && n < 20) begin
         @(negedge PCLK);
         n++;
      end
      check({tag, " gnt"}, gnt, e_gnt);
      if (gnt == 2'b00) return;
      if (e_lat != 0) check({tag, " latency"}, n, e_lat);
      check({tag, " setup transfer"}, transfer, 1'b1);
      check({tag, " READ_WRITE"}, READ_WRITE, e_rw);
      check({tag, " write_paddr"}, apb_write_paddr, e_addr);
      check({tag, " read_paddr"}, apb_read_paddr, e_addr);
      check({tag, " write_data"}, apb_write_data, e_wd);
      if (scr) begin
         if (e_gnt[0]) begin
            req0 = 1'b0; wr0 = ~wr0; addr0 = ADDR_W'($urandom); wdata0 = DATA_W'($urandom);
         end else begin
            req1 = 1'b0; wr1 = ~wr1; addr1 = ADDR_W'($urandom); wdata1 = DATA_W'($urandom);
         end
      end
      @(negedge PCLK);
      for (int k = 0; k <= wait_c; k++) begin
         check({tag, " access transfer"}, transfer, 1'b1);
         check({tag, " access gnt"}, gnt, e_gnt);
         check({tag, " access addr"}, apb_write_paddr, e_addr);
         check({tag, " access data"}, apb_write_data, e_wd);
         check({tag, " access rw"}, READ_WRITE, e_rw);
         check({tag, " early done"}, {done1, done0}, 2'b00);
         m_pready          = (k == wait_c);
         apb_read_data_out = (k == wait_c) ? brd : DATA_W'($urandom);
         PSLVERR           = (k == wait_c) ? perr : 1'($urandom);
         @(negedge PCLK);
      end
      m_pready = 1'b0;
      PSLVERR = 1'b0;
      apb_read_data_out = DATA_W'($urandom);
      check({tag, " done0"}, done0, e_gnt[0]);
      check({tag, " done1"}, done1, e_gnt[1]);
      check({tag, " rdata"}, rdata, e_rd);
      check({tag, " err"}, err, e_err);
      check({tag, " done transfer"}, transfer, 1'b0);
      check({tag, " done gnt"}, gnt, 2'b00);
   endtask

   vec_t vecs[9];

   initial begin
      int lastm, w, cnt, waitc;
      logic wr_w, perr;
      logic [ADDR_W-1:0] a_w;
      logic [DATA_W-1:0] d_w, brd;

      vecs[0] = '{1,0,9'h003,8'h00, 1,0,9'h103,8'h00, 8'h06,0,0,0, 2'b01,1,9'h003,8'h00,8'h06,0,1};
      vecs[1] = '{0,0,9'h000,8'h00, 1,0,9'h103,8'h00, 8'h03,0,0,0, 2'b10,1,9'h103,8'h00,8'h03,0,2};
      vecs[2] = '{1,1,9'h005,8'h0A, 0,0,9'h000,8'h00, 8'hEE,0,0,0, 2'b01,0,9'h005,8'h0A,8'h00,0,2};
      vecs[3] = '{1,0,9'h02D,8'h11, 0,0,9'h000,8'h00, 8'h5A,1,0,0, 2'b01,1,9'h02D,8'h11,8'h5A,1,2};
      vecs[4] = '{0,0,9'h000,8'h00, 1,0,9'h1FF,8'h22, 8'hA5,0,3,0, 2'b10,1,9'h1FF,8'h22,8'hA5,0,2};
      vecs[5] = '{1,1,9'h0FF,8'h3C, 1,0,9'h100,8'h00, 8'h99,0,2,1, 2'b01,0,9'h0FF,8'h3C,8'h00,0,2};
      vecs[6] = '{1,1,9'h011,8'h77, 1,1,9'h122,8'h88, 8'h00,0,1,0, 2'b10,0,9'h122,8'h88,8'h00,0,2};
      vecs[7] = '{1,1,9'h011,8'h77, 1,1,9'h122,8'h88, 8'h00,1,0,0, 2'b01,0,9'h011,8'h77,8'h00,1,2};
      vecs[8] = '{0,0,9'h000,8'h00, 1,0,9'h1AB,8'h00, 8'h3C,0,0,0, 2'b10,1,9'h1AB,8'h00,8'h3C,0,2};

      // Reset state
      repeat (2) @(negedge PCLK);
      check("reset gnt", gnt, 2'b00);
      check("reset done", {done1, done0}, 2'b00);
      check("reset transfer", transfer, 1'b0);
      check("reset READ_WRITE", READ_WRITE, 1'b0);
      check("reset rdata", rdata, 8'h00);
      check("reset err", err, 1'b0);
      check("reset paddr", {apb_write_paddr, apb_read_paddr}, 18'h0);
      check("reset wdata", apb_write_data, 8'h00);
      PRESET = 1'b0;

      for (int i = 0; i < 9; i++) begin
         req0 = vecs[i].r0; wr0 = vecs[i].w0; addr0 = vecs[i].a0; wdata0 = vecs[i].d0;
         req1 = vecs[i].r1; wr1 = vecs[i].w1; addr1 = vecs[i].a1; wdata1 = vecs[i].d1;
         run_txn($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_rw, vecs[i].e_addr,
                 vecs[i].e_wd, vecs[i].brd, vecs[i].perr, vecs[i].wait_c, vecs[i].scr,
                 vecs[i].e_rd, vecs[i].e_err, vecs[i].e_lat);
      end

      // Fairness with both clients holding requests (requester 1 served last).
      req0 = 1'b1; wr0 = 1'b0; addr0 = 9'h0AA; wdata0 = 8'h00;
      req1 = 1'b1; wr1 = 1'b0; addr1 = 9'h155; wdata1 = 8'h00;
      for (int t = 0; t < 6; t++) begin
         brd = DATA_W'($urandom);
         run_txn($sformatf("fair%0d", t), (t % 2 == 0) ? 2'b01 : 2'b10, 1'b1,
                 (t % 2 == 0) ? 9'h0AA : 9'h155, 8'h00, brd, 1'b0, t % 3, 1'b0, brd, 1'b0, 2);
      end
      lastm = 1;

      // Randomized traffic against the round-robin model.
      for (int t = 0; t < 40; t++) begin
         if (req0 && req1) w = (lastm == 0) ? 1 : 0;
         else w = req1 ? 1 : 0;
         wr_w  = w ? wr1 : wr0;
         a_w   = w ? addr1 : addr0;
         d_w   = w ? wdata1 : wdata0;
         brd   = DATA_W'($urandom);
         perr  = 1'($urandom);
         waitc = $urandom_range(0, 3);
         run_txn($sformatf("rnd%0d", t), w ? 2'b10 : 2'b01, ~wr_w, a_w, d_w, brd, perr, waitc,
                 1'b0, wr_w ? 8'h00 : brd, perr, 0);
         lastm = w;
         if (w == 0) begin
            req0 = 1'($urandom);
            wr0 = 1'($urandom); addr0 = ADDR_W'($urandom); wdata0 = DATA_W'($urandom);
            if (!req1) begin
               req1 = 1'($urandom);
               wr1 = 1'($urandom); addr1 = ADDR_W'($urandom); wdata1 = DATA_W'($urandom);
            end
         end else begin
            req1 = 1'($urandom);
            wr1 = 1'($urandom); addr1 = ADDR_W'($urandom); wdata1 = DATA_W'($urandom);
            if (!req0) begin
               req0 = 1'($urandom);
               wr0 = 1'($urandom); addr0 = ADDR_W'($urandom); wdata0 = DATA_W'($urandom);
            end
         end
         if (!req0 && !req1) begin
            if ($urandom_range(0, 1) == 0) req0 = 1'b1;
            else req1 = 1'b1;
         end
      end

      // Bridge that never answers.
      req0 = 1'b1; wr0 = 1'b0; addr0 = 9'h044; req1 = 1'b0;
      cnt = 0;
      @(negedge PCLK);
      while (gnt == 2'b00 && cnt < 20) begin
         @(negedge PCLK);
         cnt++;
      end
      check("stall gnt", gnt, 2'b01);
      apb_read_data_out = 8'hC3;
      m_pready = 1'b0;
      cnt = 0;
      @(negedge PCLK);
`ifdef ARB_TIMEOUT_EN
      while (transfer && cnt < 100) begin
         cnt++;
         @(negedge PCLK);
      end
      check("timeout access cycles", cnt, TIMEOUT);
      check("timeout done0", done0, 1'b1);
      check("timeout err", err, 1'b1);
      check("timeout rdata", rdata, 8'h00);
`else
      for (int k = 0; k < 40; k++) begin
         if (transfer && !done0 && !done1) cnt++;
         if (k == 39) m_pready = 1'b1;
         @(negedge PCLK);
      end
      m_pready = 1'b0;
      check("stall held cycles", cnt, 40);
      check("stall done0", done0, 1'b1);
      check("stall rdata", rdata, 8'hC3);
`endif
      req0 = 1'b0;

      // Reset in the middle of an ACCESS granted to requester 1.
      req1 = 1'b1; wr1 = 1'b0; addr1 = 9'h1C0; wdata1 = 8'h00;
      cnt = 0;
      @(negedge PCLK);
      while (gnt == 2'b00 && cnt < 20) begin
         @(negedge PCLK);
         cnt++;
      end
      check("prereset gnt", gnt, 2'b10);
      @(negedge PCLK);
      PRESET = 1'b1;
      req0 = 1'b1; wr0 = 1'b0; addr0 = 9'h0C0; wdata0 = 8'h00;
      @(negedge PCLK);
      check("midreset transfer", transfer, 1'b0);
      check("midreset gnt", gnt, 2'b00);
      check("midreset done", {done1, done0}, 2'b00);
      PRESET = 1'b0;
      run_txn("post_reset0", 2'b01, 1'b1, 9'h0C0, 8'h00, 8'h4B, 1'b0, 0, 1'b0, 8'h4B, 1'b0, 1);
      req0 = 1'b0;
      run_txn("post_reset1", 2'b10, 1'b1, 9'h1C0, 8'h00, 8'hB4, 1'b0, 1, 1'b0, 8'hB4, 1'b0, 2);
      req1 = 1'b0;
      repeat (3) @(negedge PCLK);
      check("idle transfer", transfer, 1'b0);

      check("done/gnt exclusivity violations", inv_viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
